result_streamer: RTL and testbench

- Downstream drain stage for the matrix processor.
- On a rising edge of the processor's done flag, captures the WIDTH x WIDTH 32-bit result matrix into a shadow register.
- Streams the captured elements out one per beat, row-major, over a valid/ready interface, so a narrow consumer (host port or logger) can read results while the processor is restarted.

---
 rtl/result_streamer.sv | 127 ++++++++++++
 tb/tb_result_streamer.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/result_streamer.sv
// Drain stage: snapshots the processor result matrix on a done rising edge and
// streams it row-major over valid/ready. Optional trailer beat: RESULT_STREAMER_CHECKSUM_EN.
module result_streamer #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic                                CLK,
  input  logic                                RST,
  input  logic                                done,
  input  logic [0:WIDTH-1][0:WIDTH-1][31:0]   result,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [31:0]                         out_data,
  output logic [IDX_W-1:0]                    out_row,
  output logic [IDX_W-1:0]                    out_col,
  output logic                                out_last,
  output logic                                busy,
  output logic                                overrun
);

  localparam int unsigned NELEM = WIDTH * WIDTH;
  localparam int unsigned CNT_W = $clog2(NELEM + 1);
`ifdef RESULT_STREAMER_CHECKSUM_EN
  localparam int unsigned LAST_K = NELEM;
  localparam logic [CNT_W-1:0] DATA_END = CNT_W'(NELEM - 1);
`else
  localparam int unsigned LAST_K = NELEM - 1;
`endif
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LAST_K);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t                            state;
  logic                              done_q;
  logic                              start;
  logic                              accept;
  logic [CNT_W-1:0]                  cnt;
  logic [CNT_W-1:0]                  nxt_cnt;
  logic [IDX_W-1:0]                  nxt_row;
  logic [IDX_W-1:0]                  nxt_col;
  logic [0:WIDTH-1][0:WIDTH-1][31:0] shadow;
`ifdef RESULT_STREAMER_CHECKSUM_EN
  logic [31:0]                       sum;
`endif

  assign start   = done & ~done_q;
  assign accept  = out_valid & out_ready;
  assign nxt_cnt = cnt + CNT_W'(1);
  assign nxt_row = IDX_W'(nxt_cnt / CNT_W'(WIDTH));
  assign nxt_col = IDX_W'(nxt_cnt % CNT_W'(WIDTH));

  // Snapshot only when a frame is launched; contents are don't-care after reset.
  always_ff @(posedge CLK) begin
    if (state == IDLE && start) shadow <= result;
  end

  // Frame sequencer with registered beat outputs.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= IDLE;
      done_q    <= 1'b0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_row   <= '0;
      out_col   <= '0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
`ifdef RESULT_STREAMER_CHECKSUM_EN
      sum       <= '0;
`endif
    end else begin
      done_q <= done;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= STREAM;
            cnt       <= '0;
            out_valid <= 1'b1;
            out_data  <= result[0][0];
            out_row   <= '0;
            out_col   <= '0;
            out_last  <= (LAST_CNT == '0);
            busy      <= 1'b1;
`ifdef RESULT_STREAMER_CHECKSUM_EN
            sum       <= '0;
`endif
          end
        end
        STREAM: begin
          if (start) overrun <= 1'b1;
          if (accept) begin
            if (cnt == LAST_CNT) begin
              state     <= IDLE;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              busy      <= 1'b0;
            end else begin
              cnt      <= nxt_cnt;
              out_last <= (nxt_cnt == LAST_CNT);
`ifdef RESULT_STREAMER_CHECKSUM_EN
              sum <= sum + out_data;
              // Trailer carries the running sum plus the element just accepted.
              if (cnt == DATA_END) begin
                out_data <= sum + out_data;
                out_row  <= IDX_W'(WIDTH - 1);
                out_col  <= IDX_W'(WIDTH - 1);
              end else begin
                out_data <= shadow[nxt_row][nxt_col];
                out_row  <= nxt_row;
                out_col  <= nxt_col;
              end
`else
              out_data <= shadow[nxt_row][nxt_col];
              out_row  <= nxt_row;
              out_col  <= nxt_col;
`endif
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_result_streamer.sv
// Self-checking bench for result_streamer: scoreboard of expected beats plus a
// table of frames and hand-written reset/overrun/backpressure sequences.
module tb_result_streamer;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned IDX_W = 2;
  localparam int unsigned NELEM = 16;
`ifdef RESULT_STREAMER_CHECKSUM_EN
  localparam bit CS = 1'b1;
  localparam int NBEATS = 17;
`else
  localparam bit CS = 1'b0;
  localparam int NBEATS = 16;
`endif

  logic                              CLK = 1'b0;
  logic                              RST;
  logic                              done;
  logic [0:WIDTH-1][0:WIDTH-1][31:0] result;
  logic                              out_valid;
  logic                              out_ready;
  logic [31:0]                       out_data;
  logic [IDX_W-1:0]                  out_row;
  logic [IDX_W-1:0]                  out_col;
  logic                              out_last;
  logic                              busy;
  logic                              overrun;

  result_streamer #(.WIDTH(WIDTH), .IDX_W(IDX_W)) dut (
    .CLK(CLK), .RST(RST), .done(done), .result(result),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_row(out_row), .out_col(out_col), .out_last(out_last),
    .busy(busy), .overrun(overrun)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0]      data;
    logic [IDX_W-1:0] row;
    logic [IDX_W-1:0] col;
    logic             last;
  } beat_t;

  typedef struct {
    logic [31:0] base;
    logic [31:0] step;
    int          mode;
    int          exp_beats;
    logic [31:0] exp_last;
  } vec_t;

  beat_t       exp_q[$];
  int          total = 0;
  int          bad = 0;
  int          acc_cnt = 0;
  logic [31:0] last_data = '0;
  int          ready_mode = 2;
  logic        phase = 1'b0;
  logic        held = 1'b0;
  beat_t       held_b;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic fill(input logic [31:0] base, input logic [31:0] step);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        result[r][c] = base + step * 32'(r * 4 + c);
  endtask

  // Reference frame: row-major elements, then the optional wrap-around sum trailer.
  task automatic push_frame(input logic [31:0] base, input logic [31:0] step);
    beat_t b;
    logic [31:0] s;
    s = '0;
    for (int k = 0; k < 16; k++) begin
      b.data = base + step * 32'(k);
      b.row  = 2'(k / 4);
      b.col  = 2'(k % 4);
      b.last = (k == 15) && !CS;
      s      = s + b.data;
      exp_q.push_back(b);
    end
    if (CS) begin
      b.data = s; b.row = 2'd3; b.col = 2'd3; b.last = 1'b1;
      exp_q.push_back(b);
    end
  endtask

  task automatic wait_acc(input int n, output int vc);
    int cyc;
    vc = 0;
    cyc = 0;
    while (acc_cnt < n && cyc < 500) begin
      @(negedge CLK);
      if (out_valid) vc++;
      cyc++;
    end
    if (acc_cnt < n) begin
      total++; bad++;
      $display("FAIL wait_acc: got %0d accepts want %0d (timeout)", acc_cnt, n);
    end
  endtask

  task automatic pulse_done();
    @(posedge CLK); #1 done = 1'b1;
    @(posedge CLK); #1 done = 1'b0;
  endtask

  // Consumer: always ready, or alternating 0,1 starting on the first valid cycle.
  always @(posedge CLK) begin
    #1;
    if (ready_mode == 0) out_ready = 1'b1;
    else if (ready_mode == 1) begin
      if (!out_valid) begin
        out_ready = 1'b0;
        phase = 1'b0;
      end else begin
        out_ready = phase;
        phase = ~phase;
      end
    end
  end

  // Monitor: stall stability and scoreboard compare on every accepted beat.
  always @(negedge CLK) begin
    if (RST) begin
      if (held) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_data", out_data, held_b.data);
        check("hold_rowcol", {28'd0, out_row, out_col}, {28'd0, held_b.row, held_b.col});
        check("hold_last", 32'(out_last), 32'(held_b.last));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_beat: got data %h want no beat", out_data);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          check("beat_data", out_data, e.data);
          check("beat_row", 32'(out_row), 32'(e.row));
          check("beat_col", 32'(out_col), 32'(e.col));
          check("beat_last", 32'(out_last), 32'(e.last));
        end
        acc_cnt++;
        last_data = out_data;
      end
      held = out_valid && !out_ready;
      held_b.data = out_data; held_b.row = out_row;
      held_b.col = out_col;   held_b.last = out_last;
    end else begin
      held = 1'b0;
    end
  end

  vec_t vecs[4];

  initial begin
    int vc;
    vecs[0] = '{32'd1,   32'd1,          1, NBEATS, CS ? 32'd136        : 32'd16};
    vecs[1] = '{32'hFFFF_FFFF, 32'd0,    0, NBEATS, CS ? 32'hFFFF_FFF0 : 32'hFFFF_FFFF};
    vecs[2] = '{32'd100, 32'd3,          1, NBEATS, CS ? 32'd1960       : 32'd145};
    vecs[3] = '{32'h10,  32'h0100_0000,  0, NBEATS, CS ? 32'h7800_0100 : 32'h0F00_0010};

    // Reset held with done and out_ready high.
    RST = 1'b0; done = 1'b1; out_ready = 1'b1; ready_mode = 2;
    fill(32'd1, 32'd1);
    repeat (3) @(posedge CLK);
    #1;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_data", out_data, 32'd0);
    check("rst_last", 32'(out_last), 32'd0);

    // Release with done already high: exactly one frame.
    push_frame(32'd1, 32'd1);
    acc_cnt = 0;
    ready_mode = 0;
    @(posedge CLK); #1 RST = 1'b1;
    wait_acc(NBEATS, vc);
    check("relfrm_vcycles", 32'(vc), 32'(NBEATS));
    repeat (10) @(negedge CLK);
    check("relfrm_no_second", 32'(out_valid), 32'd0);
    check("relfrm_beats", 32'(acc_cnt), 32'(NBEATS));
    done = 1'b0;
    repeat (2) @(posedge CLK);

    // Basic frame: latency, level-held done, result changed after capture.
    fill(32'd1, 32'd1);
    push_frame(32'd1, 32'd1);
    acc_cnt = 0;
    @(posedge CLK); #1 done = 1'b1;
    @(negedge CLK);
    check("lat_pre_valid", 32'(out_valid), 32'd0);
    @(posedge CLK); #1 fill(32'hFFFF_FFFF, 32'd0);
    @(negedge CLK);
    check("lat_valid", 32'(out_valid), 32'd1);
    check("lat_busy", 32'(busy), 32'd1);
    wait_acc(NBEATS, vc);
    check("basic_vcycles", 32'(vc + 1), 32'(NBEATS));
    @(negedge CLK);
    check("basic_busy_fall", 32'(busy), 32'd0);
    check("basic_valid_fall", 32'(out_valid), 32'd0);
    repeat (10) @(negedge CLK);
    check("basic_no_second", 32'(acc_cnt), 32'(NBEATS));
    done = 1'b0;

    // Table of frames with a single-cycle done pulse.
    foreach (vecs[i]) begin
      ready_mode = vecs[i].mode;
      fill(vecs[i].base, vecs[i].step);
      push_frame(vecs[i].base, vecs[i].step);
      acc_cnt = 0;
      pulse_done();
      wait_acc(vecs[i].exp_beats, vc);
      if (vecs[i].mode == 0) check("tbl_vcycles", 32'(vc), 32'(vecs[i].exp_beats));
      check("tbl_last_data", last_data, vecs[i].exp_last);
      @(negedge CLK);
      check("tbl_busy_end", 32'(busy), 32'd0);
      check("tbl_overrun", 32'(overrun), 32'd0);
      check("tbl_beats", 32'(acc_cnt), 32'(vecs[i].exp_beats));
      check("tbl_q_empty", 32'(exp_q.size()), 32'd0);
    end

    // Overrun: second done edge mid-frame is ignored but flagged.
    ready_mode = 0;
    fill(32'd1, 32'd1);
    push_frame(32'd1, 32'd1);
    acc_cnt = 0;
    @(posedge CLK); #1 done = 1'b1;
    wait_acc(3, vc);
    @(posedge CLK); #1 done = 1'b0;
    wait_acc(5, vc);
    @(posedge CLK); #1 done = 1'b1;
    fill(32'd500, 32'd7);
    @(negedge CLK);
    check("ovr_before", 32'(overrun), 32'd0);
    @(negedge CLK);
    check("ovr_set", 32'(overrun), 32'd1);
    wait_acc(NBEATS, vc);
    check("ovr_last_data", last_data, CS ? 32'd136 : 32'd16);
    repeat (6) @(negedge CLK);
    check("ovr_sticky", 32'(overrun), 32'd1);
    check("ovr_no_recapture", 32'(acc_cnt), 32'(NBEATS));
    done = 1'b0;
    repeat (2) @(posedge CLK);

    // Reset mid-frame, then a fresh frame from [0][0].
    fill(32'd1, 32'd1);
    push_frame(32'd1, 32'd1);
    acc_cnt = 0;
    pulse_done();
    wait_acc(5, vc);
    @(posedge CLK); #1 RST = 1'b0;
    #1;
    check("async_valid", 32'(out_valid), 32'd0);
    check("async_busy", 32'(busy), 32'd0);
    check("async_overrun", 32'(overrun), 32'd0);
    check("async_data", out_data, 32'd0);
    exp_q.delete();
    @(posedge CLK); #1 RST = 1'b1;
    fill(32'd100, 32'd1);
    push_frame(32'd100, 32'd1);
    acc_cnt = 0;
    pulse_done();
    wait_acc(NBEATS, vc);
    check("post_rst_last", last_data, CS ? 32'd1720 : 32'd115);
    @(negedge CLK);
    check("post_rst_q_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
